// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for both ends of the serial shift-register link (this
// transmitter and the serial-in receiver chain).
//
// Contents:
//   state_e    - transmitter FSM state encoding (IDLE / SHIFT / PARITY)
//   frame_len  - serial frame length for a given data width
//   calc_parity- even parity (XOR reduction) of a data word
//
// Optional feature macro: SHIFT_REG_PIPO_PARITY_EN
//   When defined, a single even-parity bit trails every frame and the PARITY
//   state exists. When undefined, frames carry data bits only.
// -----------------------------------------------------------------------------
package shift_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef SHIFT_REG_PIPO_PARITY_EN
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
`else
    ST_SHIFT  = 2'd1
`endif
  } state_e;

  // Number of serial cycles one frame occupies on the line.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef SHIFT_REG_PIPO_PARITY_EN
    return width + 32'd1;
`else
    return width;
`endif
  endfunction

  // Even parity: the parity bit makes the total count of ones even, which is
  // simply the XOR of all data bits. Callers zero-extend narrower words.
  function automatic logic calc_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_reg_piso_tx_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Down-counter tracking which bit of the frame is on the serial line.
//
// Ports:
//   i_clk      - clock, rising edge
//   i_reset_n  - asynchronous active-low reset (count clears to zero)
//   i_load     - load i_load_val (takes priority over i_en)
//   i_en       - decrement by one
//   i_load_val - value loaded on i_load
//   o_count    - current count
//   o_tc       - terminal count, high when o_count is zero
// -----------------------------------------------------------------------------
module piso_bit_counter #(
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [CW-1:0] i_load_val,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  // Count register: a reload wins over a decrement so back-to-back frames
  // restart cleanly on the last-bit cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);

endmodule : piso_bit_counter

// File: rtl/shift_reg_piso_tx.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_tx
// Parallel-in, serial-out transmitter. A WIDTH-bit word accepted over the
// load_valid/load_ready handshake is driven onto sdo one bit per clock,
// starting the cycle after the accept. frame_start marks the first bit and
// done marks the last bit of each frame. Holding load_valid high streams
// words with no idle gap: the next word is accepted on the done cycle.
//
// Parameters:
//   WIDTH      - data bits per frame (2..32)
//   MSB_FIRST  - 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   IDLE_LEVEL - sdo level outside a frame
//
// Ports:
//   clk         - clock, rising edge
//   reset_n     - asynchronous active-low reset; abandons any frame
//   pdi         - parallel word, sampled only on an accepted load
//   load_valid  - pdi is valid
//   load_ready  - a word can be accepted this cycle (state/counter only)
//   sdo         - serial data out
//   sdo_valid   - sdo carries a frame bit
//   frame_start - first bit of a frame is on sdo
//   done        - last bit of a frame is on sdo
//   busy        - a frame is in progress
//
// Optional feature macro: SHIFT_REG_PIPO_PARITY_EN
//   When defined, an even-parity bit follows the data bits (frame is
//   WIDTH+1 cycles), done and the back-to-back accept point move to that
//   parity cycle.
// -----------------------------------------------------------------------------
module shift_reg_piso_tx
  import shift_reg_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pdi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    w_count;
  logic             w_tc;
  logic             w_load;
  logic             w_shift_en;
  logic             w_out_bit;
`ifdef SHIFT_REG_PIPO_PARITY_EN
  logic             r_parity;
`endif

  piso_bit_counter #(
    .CW(CW)
  ) u_bit_counter (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_load     (w_load),
    .i_en       (w_shift_en),
    .i_load_val (CW'(WIDTH - 1)),
    .o_count    (w_count),
    .o_tc       (w_tc)
  );

  // The bit currently at the output end of the shift register.
  assign w_out_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift register: freezes the word at accept, then moves one position
  // toward the output end every serial cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
    end else if (w_load) begin
      r_shift <= pdi;
    end else if (w_shift_en) begin
      if (MSB_FIRST) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end else begin
        r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      end
    end else begin
      r_shift <= r_shift;
    end
  end

`ifdef SHIFT_REG_PIPO_PARITY_EN
  // Parity is captured at accept because the shift register no longer holds
  // the whole word by the time the parity bit goes out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= calc_parity(32'(pdi));
    end else begin
      r_parity <= r_parity;
    end
  end
`endif

  // Next-state and output decode; outputs depend only on registered state,
  // so load_valid never reaches sdo/markers or load_ready combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift_en  = 1'b0;
    load_ready  = 1'b0;
    sdo         = IDLE_LEVEL;
    sdo_valid   = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sdo         = w_out_bit;
        sdo_valid   = 1'b1;
        busy        = 1'b1;
        frame_start = (w_count == CW'(WIDTH - 1));
        w_shift_en  = 1'b1;
        if (w_tc) begin
`ifdef SHIFT_REG_PIPO_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          // Last data bit: this is the back-to-back accept point.
          done       = 1'b1;
          load_ready = 1'b1;
          if (load_valid) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
`ifdef SHIFT_REG_PIPO_PARITY_EN
      ST_PARITY: begin
        sdo        = r_parity;
        sdo_valid  = 1'b1;
        busy       = 1'b1;
        done       = 1'b1;
        load_ready = 1'b1;
        if (load_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : shift_reg_piso_tx

// File: tb/tb_shift_reg_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_piso_tx
// Self-checking bench for shift_reg_piso_tx. Two instances share clock, reset
// and pdi: dut_a is MSB-first with idle level 0, dut_b is LSB-first with idle
// level 1. Expected serial streams are built from the words themselves (bit
// order, even parity, frame length) and compared cycle by cycle as the vector
// {sdo, sdo_valid, frame_start, done, busy, load_ready}.
// Honours SHIFT_REG_PIPO_PARITY_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_shift_reg_piso_tx;

  localparam int W = 8;
`ifdef SHIFT_REG_PIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         reset_n;
  logic [W-1:0] pdi;
  logic         lv_a, lv_b;
  logic         a_ready, a_sdo, a_valid, a_fs, a_done, a_busy;
  logic         b_ready, b_sdo, b_valid, b_fs, b_done, b_busy;
  logic [5:0]   obs_a, obs_b, obs;
  logic         sel;          // 0: dut_a under test, 1: dut_b under test
  logic [W-1:0] word_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .pdi(pdi), .load_valid(lv_a),
    .load_ready(a_ready), .sdo(a_sdo), .sdo_valid(a_valid),
    .frame_start(a_fs), .done(a_done), .busy(a_busy)
  );

  shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .pdi(pdi), .load_valid(lv_b),
    .load_ready(b_ready), .sdo(b_sdo), .sdo_valid(b_valid),
    .frame_start(b_fs), .done(b_done), .busy(b_busy)
  );

  assign obs_a = {a_sdo, a_valid, a_fs, a_done, a_busy, a_ready};
  assign obs_b = {b_sdo, b_valid, b_fs, b_done, b_busy, b_ready};
  assign obs   = sel ? obs_b : obs_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_lv(input logic v);
    lv_a = sel ? 1'b0 : v;
    lv_b = sel ? v : 1'b0;
  endtask

  // Stream every word in word_q back to back through the selected DUT and
  // check each serial cycle plus the return to idle.
  task automatic run_stream(input string name);
    logic [5:0]   exp_q[$];
    logic [W-1:0] w;
    logic         b;
    logic         msb;
    int           n_words;
    int           nxt;
    n_words = word_q.size();
    msb     = ~sel;
    for (int j = 0; j < n_words; j++) begin
      w = word_q[j];
      for (int i = 0; i < FL; i++) begin
        if (i < W) b = msb ? w[W-1-i] : w[i];
        else       b = ^w;
        exp_q.push_back({b, 1'b1, (i == 0), (i == FL - 1), 1'b1, (i == FL - 1)});
      end
    end
    @(negedge clk);
    pdi = word_q[0];
    set_lv(1'b1);
    for (int e = 0; e < exp_q.size(); e++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_q[e])
        $display("FAIL %s cycle %0d: {sdo,valid,start,done,busy,ready} got %b expected %b",
                 name, e, obs, exp_q[e]);
      else
        n_pass++;
      nxt = e + 1;
      if ((nxt % FL) == 0 && (nxt / FL) < n_words) begin
        pdi = word_q[nxt / FL];
        set_lv(1'b1);
      end else if ((nxt % FL) == 0) begin
        pdi = W'($urandom);
        set_lv(1'b0);
      end else begin
        pdi = W'($urandom);
        set_lv(1'($urandom_range(0, 1)));
      end
    end
    @(negedge clk);
    n_checks++;
    if (obs !== {sel, 5'b00001})
      $display("FAIL %s idle-after: got %b expected %b", name, obs, {sel, 5'b00001});
    else
      n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sel     = 1'b0;
    lv_a    = 1'b0;
    lv_b    = 1'b0;
    pdi     = 8'hA5;
    repeat (2) @(negedge clk);
    lv_a = 1'b1;
    lv_b = 1'b1;
    @(negedge clk);
    lv_a = 1'b0;
    lv_b = 1'b0;
    n_checks++;
    if (obs_a !== 6'b000001) $display("FAIL reset_a: got %b expected %b", obs_a, 6'b000001);
    else n_pass++;
    n_checks++;
    if (obs_b !== 6'b100001) $display("FAIL reset_b: got %b expected %b", obs_b, 6'b100001);
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_a !== 6'b000001) $display("FAIL reset_release_a: got %b expected %b", obs_a, 6'b000001);
    else n_pass++;
    n_checks++;
    if (obs_b !== 6'b100001) $display("FAIL reset_release_b: got %b expected %b", obs_b, 6'b100001);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    sel = 1'b0;
    word_q.delete();
    word_q.push_back(8'hA5);
    run_stream("single_A5");
  endtask

  task automatic test_lsb_first();
    sel = 1'b1;
    word_q.delete();
    word_q.push_back(8'h01);
    run_stream("lsb_01");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    word_q.delete();
    word_q.push_back(8'hFF);
    word_q.push_back(8'h00);
    run_stream("b2b_FF_00");
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] exp;
    logic [7:0] w;
    sel = 1'b0;
    w   = 8'hA5;
    @(negedge clk);
    pdi = w;
    set_lv(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_lv(1'b0);
      pdi = W'($urandom);
      exp = {w[W-1-i], 1'b1, (i == 0), 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL midreset_bit%0d: got %b expected %b", i, obs, exp);
      else n_pass++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 6'b000001) $display("FAIL midreset_async: got %b expected %b", obs, 6'b000001);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 6'b000001) $display("FAIL midreset_release: got %b expected %b", obs, 6'b000001);
    else n_pass++;
    word_q.delete();
    word_q.push_back(8'h3C);
    run_stream("after_reset_3C");
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 4; k++) begin
      sel = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 3);
      word_q.delete();
      for (int j = 0; j < n; j++) word_q.push_back(W'($urandom));
      run_stream($sformatf("random%0d", k));
    end
  endtask

`ifdef SHIFT_REG_PIPO_PARITY_EN
  task automatic test_parity();
    sel = 1'b0;
    word_q.delete();
    word_q.push_back(8'h07);
    run_stream("parity_07");
    word_q.delete();
    word_q.push_back(8'hA5);
    run_stream("parity_A5");
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SHIFT_REG_PIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_shift_reg_piso_tx
